// File: rtl/thread_sched_if.sv
// Issue handshake and redirect bundle between the thread scheduler and the pipeline.
// The master modport is the scheduler side; the slave modport is the pipeline side.
interface thread_sched_if;
  localparam int unsigned PC_W = 16;

  logic            issue_valid;
  logic            issue_tid;
  logic [PC_W-1:0] issue_pc;
  logic            issue_ready;
  logic            issue_pre;
  logic            jump_valid;
  logic            jump_tid;
  logic [PC_W-1:0] jump_target;

  modport master (
    output issue_valid, issue_tid, issue_pc,
    input  issue_ready, issue_pre, jump_valid, jump_tid, jump_target
  );

  modport slave (
    input  issue_valid, issue_tid, issue_pc,
    output issue_ready, issue_pre, jump_valid, jump_tid, jump_target
  );
endinterface

// File: rtl/thread_sched.sv
// Two-thread fine-grained issue scheduler: alternates between eligible threads,
// pins issue to one thread after a prefix, and tracks per-thread sticky halts.
module thread_sched #(
  parameter logic [15:0] T1_START = 16'h8000,
  parameter logic [15:0] T0_START = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           stall,
  input  logic [1:0]           halt_req,
  thread_sched_if.master       bus,
  output logic [1:0]           halted,
  output logic                 halt
);
  localparam int unsigned PC_W = 16;

  typedef enum logic [1:0] {RUN, LOCK, HALT} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc [2];
  logic            last_tid;
  logic            lock_tid;
  logic            lock_tid_nxt;
  logic            other_tid;
  logic [1:0]      eligible;
  logic [1:0]      halted_nxt;
  logic            grant_valid;
  logic            grant_tid;
  logic            fire;

  // Issue arbitration: prefer the thread that did not issue last; a lock pins one thread.
  always_comb begin
    grant_valid = 1'b0;
    grant_tid   = 1'b0;
    eligible    = ~halted & ~stall;
    other_tid   = ~last_tid;
    if (reset) begin
      case (state)
        RUN: begin
          if (eligible[other_tid]) begin
            grant_valid = 1'b1;
            grant_tid   = other_tid;
          end else if (eligible[last_tid]) begin
            grant_valid = 1'b1;
            grant_tid   = last_tid;
          end
        end
        LOCK: begin
          if (eligible[lock_tid]) begin
            grant_valid = 1'b1;
            grant_tid   = lock_tid;
          end
        end
        default: begin
          grant_valid = 1'b0;
          grant_tid   = 1'b0;
        end
      endcase
    end
  end

  assign bus.issue_valid = grant_valid;
  assign bus.issue_tid   = grant_tid;
  assign bus.issue_pc    = pc[grant_tid];
  assign fire            = grant_valid & bus.issue_ready;

  // Next mode: a halted lock owner releases the lock; both halted parks the scheduler.
  always_comb begin
    halted_nxt   = halted | halt_req;
    state_nxt    = state;
    lock_tid_nxt = lock_tid;
    if (fire) begin
      if (bus.issue_pre) begin
        state_nxt    = LOCK;
        lock_tid_nxt = grant_tid;
      end else begin
        state_nxt = RUN;
      end
    end
    if ((state_nxt == LOCK) && halted_nxt[lock_tid_nxt]) begin
      state_nxt = RUN;
    end
    if (&halted_nxt) begin
      state_nxt = HALT;
    end
    if (state == HALT) begin
      state_nxt    = HALT;
      lock_tid_nxt = lock_tid;
    end
  end

  // A redirect is written after the increment so it wins for the same thread.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc[0]    <= T0_START;
      pc[1]    <= T1_START;
      halted   <= 2'b00;
      halt     <= 1'b0;
      state    <= RUN;
      last_tid <= 1'b1;
      lock_tid <= 1'b0;
    end else if (state != HALT) begin
      if (fire) begin
        pc[grant_tid] <= PC_W'(pc[grant_tid] + PC_W'(1));
        last_tid      <= grant_tid;
      end
      if (bus.jump_valid && !halted[bus.jump_tid]) begin
        pc[bus.jump_tid] <= bus.jump_target;
      end
      halted   <= halted_nxt;
      state    <= state_nxt;
      lock_tid <= lock_tid_nxt;
      halt     <= (state_nxt == HALT);
    end
  end
endmodule

// File: tb/tb_thread_sched.sv
// Self-checking bench for thread_sched: directed scenarios plus randomized
// traffic compared against a rule-level model of the scheduler.
module tb_thread_sched;
  logic       clk;
  logic       reset;
  logic [1:0] stall;
  logic [1:0] halt_req;
  logic [1:0] halted;
  logic       halt;

  thread_sched_if bus ();

  thread_sched dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .halt_req (halt_req),
    .bus      (bus),
    .halted   (halted),
    .halt     (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  bit [15:0] m_pc [2];
  bit [1:0]  m_halted;
  bit        m_lock;
  bit        m_lock_tid;
  bit        m_last;
  bit        m_halt;

  function automatic void model_grant(output bit v, output bit t);
    bit [1:0] elig;
    v = 1'b0;
    t = 1'b0;
    elig = ~m_halted & ~stall;
    if (reset === 1'b1 && !m_halt) begin
      if (m_lock) begin
        if (elig[m_lock_tid]) begin v = 1'b1; t = m_lock_tid; end
      end else if (elig[!m_last]) begin
        v = 1'b1; t = !m_last;
      end else if (elig[m_last]) begin
        v = 1'b1; t = m_last;
      end
    end
  endfunction

  function automatic void model_update();
    bit v, t, f;
    model_grant(v, t);
    f = v && (bus.issue_ready === 1'b1);
    if (reset !== 1'b1) begin
      m_pc[0] = 16'h0000; m_pc[1] = 16'h8000;
      m_halted = 2'b00; m_lock = 1'b0; m_lock_tid = 1'b0;
      m_last = 1'b1; m_halt = 1'b0;
    end else if (!m_halt) begin
      if (f) begin
        m_pc[t] = m_pc[t] + 16'd1;
        m_last  = t;
        if (bus.issue_pre === 1'b1) begin m_lock = 1'b1; m_lock_tid = t; end
        else m_lock = 1'b0;
      end
      if (bus.jump_valid === 1'b1 && !m_halted[bus.jump_tid]) m_pc[bus.jump_tid] = bus.jump_target;
      m_halted = m_halted | halt_req;
      if (m_lock && m_halted[m_lock_tid]) m_lock = 1'b0;
      if (&m_halted) m_halt = 1'b1;
    end
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 2'b00; halt_req = 2'b00;
    bus.issue_ready = 1'b1; bus.issue_pre = 1'b0;
    bus.jump_valid = 1'b0; bus.jump_tid = 1'b0; bus.jump_target = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    total++;
    if (bus.issue_valid !== 1'b0) $display("FAIL reset_valid_forced: got %b want 0", bus.issue_valid);
    else passed++;
    tick();
    total++;
    if ({halted, halt} !== 3'b000) $display("FAIL reset_flags: got halted=%b halt=%b want 00/0", halted, halt);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b0, 16'h0000})
      $display("FAIL reset_first_grant: got v=%b tid=%b pc=%h want 1/0/0000", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    else passed++;
    tick();
  endtask

  task automatic test_round_robin();
    logic        exp_tid [4];
    logic [15:0] exp_pc  [4];
    exp_tid = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_pc  = '{16'h0000, 16'h8000, 16'h0001, 16'h8001};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, exp_tid[i], exp_pc[i]})
        $display("FAIL round_robin[%0d]: got v=%b tid=%b pc=%h want 1/%b/%h", i,
                 bus.issue_valid, bus.issue_tid, bus.issue_pc, exp_tid[i], exp_pc[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    stall = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b0, 16'(i)})
        $display("FAIL stall_t1[%0d]: got v=%b tid=%b pc=%h want 1/0/%h", i,
                 bus.issue_valid, bus.issue_tid, bus.issue_pc, 16'(i));
      else passed++;
      tick();
    end
    stall = 2'b00;
    #1;
    total++;
    if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b1, 16'h8000})
      $display("FAIL stall_release: got v=%b tid=%b pc=%h want 1/1/8000", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    else passed++;
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    bus.issue_pre = 1'b1;
    #1;
    total++;
    if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b0, 16'h0000})
      $display("FAIL lock_prefix: got v=%b tid=%b pc=%h want 1/0/0000", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    else passed++;
    tick();
    bus.issue_pre = 1'b0;
    stall = 2'b01;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (bus.issue_valid !== 1'b0) $display("FAIL lock_hold[%0d]: got v=%b tid=%b want v=0", i, bus.issue_valid, bus.issue_tid);
      else passed++;
      tick();
    end
    stall = 2'b00;
    #1;
    total++;
    if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b0, 16'h0001})
      $display("FAIL lock_resume: got v=%b tid=%b pc=%h want 1/0/0001", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    else passed++;
    tick();
    #1;
    total++;
    if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b1, 16'h8000})
      $display("FAIL lock_back_to_run: got v=%b tid=%b pc=%h want 1/1/8000", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    else passed++;
    tick();
  endtask

  task automatic test_jump();
    do_reset();
    bus.jump_valid = 1'b1; bus.jump_tid = 1'b1; bus.jump_target = 16'h8005;
    tick();
    stall = 2'b10;
    bus.jump_tid = 1'b0; bus.jump_target = 16'hFFFF;
    tick();
    stall = 2'b00;
    bus.jump_tid = 1'b1; bus.jump_target = 16'h1234;
    #1;
    total++;
    if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b1, 16'h8005})
      $display("FAIL jump_t1_at_8005: got v=%b tid=%b pc=%h want 1/1/8005", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    else passed++;
    tick();
    bus.jump_valid = 1'b0;
    #1;
    total++;
    if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b0, 16'hFFFF})
      $display("FAIL jump_override_inc: got v=%b tid=%b pc=%h want 1/0/FFFF", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    else passed++;
    tick();
    #1;
    total++;
    if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b1, 16'h1234})
      $display("FAIL jump_target_loaded: got v=%b tid=%b pc=%h want 1/1/1234", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    else passed++;
    tick();
    #1;
    total++;
    if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b0, 16'h0000})
      $display("FAIL pc_wrap: got v=%b tid=%b pc=%h want 1/0/0000", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    else passed++;
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    halt_req = 2'b01;
    tick();
    halt_req = 2'b00;
    #1;
    total++;
    if ({halted, halt} !== 3'b010) $display("FAIL halt_t0_flag: got halted=%b halt=%b want 01/0", halted, halt);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b1, 16'(16'h8000 + i)})
        $display("FAIL halt_only_t1[%0d]: got v=%b tid=%b pc=%h want 1/1/%h", i,
                 bus.issue_valid, bus.issue_tid, bus.issue_pc, 16'(16'h8000 + i));
      else passed++;
      tick();
    end
    halt_req = 2'b10;
    tick();
    halt_req = 2'b00;
    #1;
    total++;
    if ({halted, halt} !== 3'b111) $display("FAIL halt_both: got halted=%b halt=%b want 11/1", halted, halt);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      stall = 2'($urandom); bus.issue_pre = 1'($urandom);
      bus.jump_valid = 1'b1; bus.jump_tid = 1'($urandom); bus.jump_target = 16'($urandom);
      #1;
      total++;
      if ({bus.issue_valid, halt} !== 2'b01) $display("FAIL halt_parked[%0d]: got v=%b halt=%b want 0/1", i, bus.issue_valid, halt);
      else passed++;
      tick();
    end
    do_reset();
    #1;
    total++;
    if ({bus.issue_valid, bus.issue_tid, bus.issue_pc, halted, halt} !== {1'b1, 1'b0, 16'h0000, 2'b00, 1'b0})
      $display("FAIL halt_exit_reset: got v=%b tid=%b pc=%h halted=%b halt=%b want 1/0/0000/00/0",
               bus.issue_valid, bus.issue_tid, bus.issue_pc, halted, halt);
    else passed++;
    tick();
  endtask

  task automatic test_reset_in_lock();
    do_reset();
    bus.issue_pre = 1'b1;
    tick();
    bus.issue_pre = 1'b0;
    reset = 1'b0; halt_req = 2'b11;
    bus.jump_valid = 1'b1; bus.jump_tid = 1'b1; bus.jump_target = 16'h8888;
    #1;
    total++;
    if (bus.issue_valid !== 1'b0) $display("FAIL lock_reset_valid: got v=%b want 0", bus.issue_valid);
    else passed++;
    tick();
    idle_inputs();
    reset = 1'b1;
    stall = 2'b01;
    #1;
    total++;
    if ({halted, halt} !== 3'b000) $display("FAIL lock_reset_flags: got halted=%b halt=%b want 00/0", halted, halt);
    else passed++;
    total++;
    if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b1, 16'h8000})
      $display("FAIL lock_reset_run_t1: got v=%b tid=%b pc=%h want 1/1/8000", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    else passed++;
    tick();
    stall = 2'b10;
    #1;
    total++;
    if ({bus.issue_valid, bus.issue_tid, bus.issue_pc} !== {1'b1, 1'b0, 16'h0000})
      $display("FAIL lock_reset_t0_pc: got v=%b tid=%b pc=%h want 1/0/0000", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    else passed++;
    tick();
  endtask

  task automatic test_random();
    bit ev, et;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ((i % 150) == 149) ? 1'b0 : 1'($urandom_range(0, 59) != 0);
      stall = 2'($urandom);
      halt_req = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.issue_pre   = 1'($urandom_range(0, 3) == 0);
      bus.issue_ready = 1'($urandom_range(0, 3) != 0);
      bus.jump_valid  = 1'($urandom_range(0, 5) == 0);
      bus.jump_tid    = 1'($urandom);
      bus.jump_target = 16'($urandom);
      #1;
      model_grant(ev, et);
      total++;
      if (bus.issue_valid !== ev) $display("FAIL rand_valid[%0d]: got %b want %b", i, bus.issue_valid, ev);
      else passed++;
      total++;
      if (bus.issue_tid !== et) $display("FAIL rand_tid[%0d]: got %b want %b", i, bus.issue_tid, et);
      else passed++;
      if (ev) begin
        total++;
        if (bus.issue_pc !== m_pc[et]) $display("FAIL rand_pc[%0d]: got %h want %h", i, bus.issue_pc, m_pc[et]);
        else passed++;
      end
      total++;
      if ({halted, halt} !== {m_halted, m_halt})
        $display("FAIL rand_halt[%0d]: got halted=%b halt=%b want %b/%b", i, halted, halt, m_halted, m_halt);
      else passed++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_stall();
    test_lock();
    test_jump();
    test_halt();
    test_reset_in_lock();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
